// File: rtl/updown_mode_counter.sv
// Up/down counter with wrap or saturate policy, programmable step,
// parallel load, terminal-count pulse and sticky boundary flags.
module updown_mode_counter #(
    parameter int WIDTH     = 10,
    parameter int MAX_VAL   = 2**WIDTH-1,
    parameter int STEP_W    = 4,
    parameter int RESET_VAL = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] step,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              clr_flags,
    output logic [WIDTH-1:0]  cnt,
    output logic              tc,
    output logic              at_max,
    output logic              at_min,
    output logic              ovf,
    output logic              unf
);

    // One spare bit above the wider operand keeps cnt+step exact.
    localparam int AW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

    localparam logic [AW-1:0]    MAX_X   = AW'(MAX_VAL);
    localparam logic [AW-1:0]    RANGE_X = AW'(MAX_VAL + 1);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_W   = WIDTH'(RESET_VAL);

    localparam logic [1:0] M_UP_WRAP = 2'b00;
    localparam logic [1:0] M_DN_WRAP = 2'b01;
    localparam logic [1:0] M_UP_SAT  = 2'b10;
    localparam logic [1:0] M_DN_SAT  = 2'b11;

    logic [AW-1:0]    cnt_x;
    logic [AW-1:0]    step_x;
    logic [AW-1:0]    sum_x;
    logic             active;
    logic             over;
    logic             under;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] load_clip;
    logic             up_evt;
    logic             dn_evt;

    assign cnt_x  = AW'(cnt);
    assign step_x = AW'(step);
    assign sum_x  = cnt_x + step_x;
    assign over   = sum_x > MAX_X;
    assign under  = step_x > cnt_x;
    assign active = en && (step != '0);

    // A full-range counter cannot be loaded above its top value.
    if (MAX_VAL == 2**WIDTH-1) begin : g_clip_full
        assign load_clip = load_val;
    end else begin : g_clip_part
        assign load_clip = (load_val > MAX_W) ? MAX_W : load_val;
    end

    always_comb begin
        cnt_nxt = cnt;
        up_evt  = 1'b0;
        dn_evt  = 1'b0;
        if (active) begin
            unique case (mode)
                M_UP_WRAP: begin
                    up_evt = over;
                    cnt_nxt = over ? WIDTH'(sum_x - RANGE_X)
                                   : WIDTH'(sum_x);
                end
                M_DN_WRAP: begin
                    dn_evt = under;
                    cnt_nxt = under ? WIDTH'(cnt_x + RANGE_X - step_x)
                                    : WIDTH'(cnt_x - step_x);
                end
                M_UP_SAT: begin
                    up_evt = over;
                    cnt_nxt = over ? MAX_W : WIDTH'(sum_x);
                end
                M_DN_SAT: begin
                    dn_evt = under;
                    cnt_nxt = under ? '0 : WIDTH'(cnt_x - step_x);
                end
                default: begin
                    cnt_nxt = cnt;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= RST_W;
            tc  <= 1'b0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (load) begin
            cnt <= load_clip;
            tc  <= 1'b0;
            ovf <= ovf & ~clr_flags;
            unf <= unf & ~clr_flags;
        end else begin
            cnt <= cnt_nxt;
            tc  <= up_evt | dn_evt;
            ovf <= (ovf & ~clr_flags) | up_evt;
            unf <= (unf & ~clr_flags) | dn_evt;
        end
    end

    assign at_max = (cnt == MAX_W);
    assign at_min = (cnt == '0);

endmodule

// File: tb/tb_updown_mode_counter.sv
// Scoreboard bench for updown_mode_counter: directed boundary
// scenarios followed by randomized traffic against a reference model.
module tb_updown_mode_counter;

    localparam int WIDTH   = 10;
    localparam int MAX_VAL = 999;
    localparam int STEP_W  = 4;
    localparam int RST_V   = 0;

    typedef struct packed {
        logic [WIDTH-1:0] cnt;
        logic             tc;
        logic             ovf;
        logic             unf;
        logic             at_max;
        logic             at_min;
    } obs_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic [STEP_W-1:0] step = '0;
    logic              load = 1'b0;
    logic [WIDTH-1:0]  load_val = '0;
    logic              clr_flags = 1'b0;
    logic [WIDTH-1:0]  cnt;
    logic              tc;
    logic              at_max;
    logic              at_min;
    logic              ovf;
    logic              unf;

    updown_mode_counter #(
        .WIDTH(WIDTH),
        .MAX_VAL(MAX_VAL),
        .STEP_W(STEP_W),
        .RESET_VAL(RST_V)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .mode(mode),
        .step(step),
        .load(load),
        .load_val(load_val),
        .clr_flags(clr_flags),
        .cnt(cnt),
        .tc(tc),
        .at_max(at_max),
        .at_min(at_min),
        .ovf(ovf),
        .unf(unf)
    );

    always #5 clk = ~clk;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_issued = 0;

    // Reference state
    int m_cnt = 0;
    bit m_tc = 0;
    bit m_ovf = 0;
    bit m_unf = 0;

    task automatic drive(input bit r, input bit e, input int m,
                         input int st, input bit ld, input int lv,
                         input bit cl);
        obs_t x;
        bit   up;
        bit   dn;
        int   range;
        @(negedge clk);
        rst       = r;
        en        = e;
        mode      = 2'(m);
        step      = STEP_W'(st);
        load      = ld;
        load_val  = WIDTH'(lv);
        clr_flags = cl;
        range = MAX_VAL + 1;
        up = 0;
        dn = 0;
        if (!r) begin
            m_cnt = RST_V;
            m_tc  = 0;
            m_ovf = 0;
            m_unf = 0;
        end else if (ld) begin
            m_cnt = (lv > MAX_VAL) ? MAX_VAL : lv;
            m_tc  = 0;
            if (cl) begin
                m_ovf = 0;
                m_unf = 0;
            end
        end else begin
            if (e && st != 0) begin
                case (m)
                    0: begin
                        up = (m_cnt + st) > MAX_VAL;
                        m_cnt = (m_cnt + st) % range;
                    end
                    1: begin
                        dn = st > m_cnt;
                        m_cnt = (m_cnt - st + range) % range;
                    end
                    2: begin
                        up = (m_cnt + st) > MAX_VAL;
                        m_cnt = up ? MAX_VAL : m_cnt + st;
                    end
                    default: begin
                        dn = st > m_cnt;
                        m_cnt = dn ? 0 : m_cnt - st;
                    end
                endcase
            end
            m_tc  = up || dn;
            m_ovf = (m_ovf && !cl) || up;
            m_unf = (m_unf && !cl) || dn;
        end
        x.cnt    = WIDTH'(m_cnt);
        x.tc     = m_tc;
        x.ovf    = m_ovf;
        x.unf    = m_unf;
        x.at_max = (m_cnt == MAX_VAL);
        x.at_min = (m_cnt == 0);
        exp_q.push_back(x);
        n_issued++;
    endtask

    // Monitor: one registered observation per clock edge.
    initial begin
        obs_t e;
        obs_t g;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = '{cnt, tc, ovf, unf, at_max, at_min};
                n_cmp++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL obs%0d got cnt=%0d tc=%b ovf=%b unf=%b max=%b min=%b exp cnt=%0d tc=%b ovf=%b unf=%b max=%b min=%b",
                             n_cmp, g.cnt, g.tc, g.ovf, g.unf, g.at_max, g.at_min,
                             e.cnt, e.tc, e.ovf, e.unf, e.at_max, e.at_min);
                end
            end
        end
    end

    initial begin
        int r;
        int lv;
        // reset, then count up five
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (5) drive(1, 1, 0, 1, 0, 0, 0);
        // up-wrap
        drive(1, 1, 0, 1, 1, 997, 0);
        drive(1, 1, 0, 3, 0, 0, 0);
        drive(1, 1, 0, 3, 0, 0, 0);
        // down-wrap then hold via step 0
        drive(1, 1, 1, 5, 1, 2, 0);
        drive(1, 1, 1, 5, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0, 0);
        drive(1, 0, 1, 5, 0, 0, 0);
        // saturate up, hold saturating, then saturate down
        drive(1, 1, 2, 7, 1, 995, 0);
        repeat (4) drive(1, 1, 2, 7, 0, 0, 0);
        drive(1, 1, 3, 15, 1, 10, 0);
        drive(1, 1, 3, 15, 0, 0, 0);
        drive(1, 1, 3, 15, 0, 0, 0);
        // exact limit hits are not events
        drive(1, 1, 2, 4, 1, 995, 1);
        drive(1, 1, 2, 4, 0, 0, 0);
        drive(1, 1, 3, 9, 1, 9, 0);
        drive(1, 1, 3, 9, 0, 0, 0);
        // load priority and clip
        drive(1, 1, 0, 5, 1, 1023, 0);
        drive(1, 1, 0, 3, 1, 998, 0);
        drive(1, 1, 0, 3, 0, 0, 1);
        drive(1, 0, 0, 3, 0, 0, 1);
        // reset during a saturating run
        drive(1, 1, 2, 7, 1, 995, 0);
        drive(1, 1, 2, 7, 0, 0, 0);
        drive(1, 1, 2, 7, 0, 0, 0);
        drive(0, 1, 2, 7, 0, 0, 0);
        repeat (3) drive(1, 1, 2, 1, 0, 0, 0);
        // randomized traffic
        repeat (2000) begin
            r = $urandom_range(0, 99);
            case ($urandom_range(0, 6))
                0: lv = 0;
                1: lv = $urandom_range(1, 15);
                2: lv = $urandom_range(984, 998);
                3: lv = 999;
                4: lv = $urandom_range(1000, 1023);
                default: lv = $urandom_range(0, 1023);
            endcase
            drive(r >= 2, $urandom_range(0, 9) < 8,
                  $urandom_range(0, 3), $urandom_range(0, 15),
                  r >= 2 && r < 12, lv, $urandom_range(0, 19) == 0);
        end
        @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0 || n_cmp != n_issued + 1) begin
            n_fail++;
            $display("FAIL drain got pending=%0d observed=%0d exp pending=0 observed=%0d",
                     exp_q.size(), n_cmp - 1, n_issued);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
